// File: rtl/prim_sequencer.sv
// prim_sequencer: program-driven initiator issuing mul/sqr/add primitives from a synchronous ROM
module prim_sequencer #(
  parameter int PC_W = 8,
  parameter int TO_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [9:0]      instr,
  output logic [1:0]      prim_mode,
  output logic            prim_rst,
  input  logic            prim_done,
  output logic            busy,
  output logic            done,
  output logic            err
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, LAUNCH, RUN, NEXT, FINISH} state_t;
  state_t state, state_n;
  logic [4:0] rep_cnt;
  logic [TO_W-1:0] to_cnt;
  logic ctrl, pc_last, timeout, ovf;
  assign ctrl = &instr[9:8];
  assign pc_last = &pc;
  assign timeout = state == RUN && !prim_done && to_cnt == {{(TO_W-1){1'b1}}, 1'b0};
  assign ovf = state == NEXT && rep_cnt == 5'd0 && pc_last;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = !ctrl ? LAUNCH : instr[7] ? FINISH : NEXT;
      LAUNCH:  state_n = RUN;
      RUN:     state_n = prim_done ? NEXT : timeout ? IDLE : RUN;
      NEXT:    state_n = rep_cnt != 5'd0 ? LAUNCH : pc_last ? IDLE : FETCH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= '0;
      prim_mode <= 2'd0;
      prim_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rep_cnt   <= 5'd0;
      to_cnt    <= '0;
    end else begin
      state    <= state_n;
      busy     <= state_n != IDLE;
      prim_rst <= state_n == IDLE || state_n == LAUNCH;
      done     <= state_n == FINISH;
      if (state == IDLE && start) begin
        pc  <= '0;
        err <= 1'b0;
      end
      if (state == DECODE) begin
        if (!ctrl) prim_mode <= instr[9:8];
        rep_cnt <= ctrl ? 5'd0 : instr[4:0];
      end
      if (state == LAUNCH) to_cnt <= '0;
      else if (state == RUN) to_cnt <= to_cnt + 1'b1;
      if (state == NEXT) begin
        if (rep_cnt != 5'd0) rep_cnt <= rep_cnt - 5'd1;
        else if (!pc_last) pc <= pc + 1'b1;
      end
      if (timeout || ovf) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prim_sequencer.sv
// tb_prim_sequencer: program table plus launch-mode scoreboard, with timeout and pc-overflow sequences
module tb_prim_sequencer;
  localparam logic [9:0] ENDW = 10'h380, NOP = 10'h300;
  logic clk = 0, rst = 0, start_a = 0, start_b = 0;
  always #5 clk = ~clk;
  logic [7:0] pc_a;
  logic [1:0] pc_b;
  logic [9:0] instr_a, instr_b;
  logic [1:0] mode_a, mode_b;
  logic prst_a, pdone_a, busy_a, done_a, err_a;
  logic prst_b, pdone_b = 0, busy_b, done_b, err_b;
  logic [9:0] rom_a [256];
  logic [9:0] rom_b [4];
  int lat = 0, pcnt = 0, launches = 0, total = 0, bad = 0;
  logic [1:0] exp_q [$];

  prim_sequencer #(.PC_W(8), .TO_W(12)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pc(pc_a), .instr(instr_a),
    .prim_mode(mode_a), .prim_rst(prst_a), .prim_done(pdone_a),
    .busy(busy_a), .done(done_a), .err(err_a));
  prim_sequencer #(.PC_W(2), .TO_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pc(pc_b), .instr(instr_b),
    .prim_mode(mode_b), .prim_rst(prst_b), .prim_done(pdone_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  always @(posedge clk) begin
    instr_a <= rom_a[pc_a];
    instr_b <= rom_b[pc_b];
    pcnt    <= prst_a ? 0 : pcnt + 1;
  end
  assign pdone_a = !prst_a && pcnt >= lat;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Each LAUNCH cycle (busy with prim_rst high) consumes one expected mode
  always @(negedge clk) begin
    if (rst && busy_a && prst_a) begin
      launches++;
      if (exp_q.size() == 0) chk("unexpected_launch", 1, 0);
      else chk("launch_mode", int'(mode_a), int'(exp_q.pop_front()));
    end
  end

  function automatic logic [9:0] w(input logic [1:0] op, input logic [4:0] rep);
    return {op, 3'b000, rep};
  endfunction

  typedef struct {
    logic [3:0][9:0] prog;
    int lat;
    bit poke;
    int exp_pc;
    int exp_launch;
  } vec_t;

  function automatic vec_t mk(input logic [9:0] w0, w1, w2, w3, input int l, input bit p,
                              input int epc, input int nl);
    mk.prog[0] = w0; mk.prog[1] = w1; mk.prog[2] = w2; mk.prog[3] = w3;
    mk.lat = l; mk.poke = p; mk.exp_pc = epc; mk.exp_launch = nl;
  endfunction

  task automatic run_a(input vec_t v, input string tag);
    int n_done;
    n_done = 0;
    for (int i = 0; i < 256; i++) rom_a[i] = ENDW;
    for (int i = 0; i < 4; i++) rom_a[i] = v.prog[i];
    lat = v.lat;
    for (int i = 0; i < 4; i++) begin
      if (v.prog[i][9:8] == 2'd3) begin
        if (v.prog[i][7]) break;
      end else for (int r = 0; r <= int'(v.prog[i][4:0]); r++) exp_q.push_back(v.prog[i][9:8]);
    end
    launches = 0;
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start_a = v.poke && c == 6;
      if (done_a) n_done++;
      if (!busy_a) break;
    end
    start_a = 0;
    chk({tag, "_idle"}, int'(busy_a), 0);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_pc"}, int'(pc_a), v.exp_pc);
    chk({tag, "_err"}, int'(err_a), 0);
    chk({tag, "_launches"}, launches, v.exp_launch);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t vecs [5];

  initial begin
    int run_cyc, n_done, wrap;
    bit seen;
    logic [1:0] prev;
    vecs[0] = mk(w(0, 0), ENDW, ENDW, ENDW, 20, 0, 1, 1);
    vecs[1] = mk(w(1, 4), w(2, 0), ENDW, ENDW, 3, 1, 2, 6);
    vecs[2] = mk(NOP, w(2, 1), ENDW, ENDW, 0, 0, 2, 2);
    vecs[3] = mk(w(0, 2), w(1, 0), NOP, ENDW, 5, 1, 3, 4);
    vecs[4] = mk(ENDW, ENDW, ENDW, ENDW, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) rom_a[i] = ENDW;
    for (int i = 0; i < 4; i++) rom_b[i] = ENDW;
    #12;
    chk("rst_prim_rst", int'(prst_a), 1);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_pc", int'(pc_a), 0);
    chk("rst_mode", int'(mode_a), 0);
    @(negedge clk) rst = 1;

    // END at address 0: done is high in the cycle after edge 2
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
    chk("end_e0_busy", int'(busy_a), 1);
    chk("end_e0_done", int'(done_a), 0);
    @(negedge clk) chk("end_e1_done", int'(done_a), 0);
    @(negedge clk) chk("end_e2_done", int'(done_a), 1);
    @(negedge clk);
    chk("end_e3_done", int'(done_a), 0);
    chk("end_e3_busy", int'(busy_a), 0);

    // Async reset in the middle of a squaring RUN
    rom_a[0] = NOP; rom_a[1] = w(1, 0); rom_a[2] = ENDW;
    lat = 1000;
    exp_q.push_back(2'd1);
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
    repeat (10) @(negedge clk);
    chk("mid_mode", int'(mode_a), 1);
    chk("mid_in_run", int'(prst_a), 0);
    chk("mid_pc", int'(pc_a), 1);
    #2 rst = 0;
    #1;
    chk("async_prim_rst", int'(prst_a), 1);
    chk("async_busy", int'(busy_a), 0);
    chk("async_pc", int'(pc_a), 0);
    chk("async_mode", int'(mode_a), 0);
    chk("async_queue", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk) rst = 1;

    for (int i = 0; i < 5; i++) run_a(vecs[i], $sformatf("vec%0d", i));

    // Timeout on the small instance: done never arrives
    rom_b[0] = w(0, 0); rom_b[1] = ENDW;
    run_cyc = 0; seen = 0;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy_b && prst_b) seen = 1;
      else if (seen && busy_b && !prst_b) run_cyc++;
      if (!busy_b) break;
      @(negedge clk);
    end
    chk("to_run_cycles", run_cyc, 15);
    chk("to_err", int'(err_b), 1);
    chk("to_busy", int'(busy_b), 0);
    chk("to_prim_rst", int'(prst_b), 1);

    // PC overflow: all NOPs with no END
    for (int i = 0; i < 4; i++) rom_b[i] = NOP;
    n_done = 0; wrap = 0; prev = 0;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    chk("ovf_err_cleared", int'(err_b), 0);
    for (int c = 0; c < 200; c++) begin
      if (done_b) n_done++;
      if (busy_b && prev == 2'd3 && pc_b == 2'd0) wrap++;
      prev = pc_b;
      if (!busy_b) break;
      @(negedge clk);
    end
    chk("ovf_err", int'(err_b), 1);
    chk("ovf_pc", int'(pc_b), 3);
    chk("ovf_busy", int'(busy_b), 0);
    chk("ovf_done", n_done, 0);
    chk("ovf_wrap", wrap, 0);
    repeat (3) @(negedge clk);
    chk("ovf_pc_hold", int'(pc_b), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
